// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage (master) and data memory (slave).
`timescale 1ns/1ps
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: unpacks EX/MEM, runs loads/stores over a req/ack port with a
// timeout abort, stalls upstream while an access is pending and emits the MEM/WB bundle.
`timescale 1ns/1ps
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [107:0]       ex_mem_in,
  mem_stage_if.master        mem_bus,
  output logic               stall,
  output logic               pc_src,
  output logic [31:0]        branch_target_out,
  output logic [70:0]        mem_wb_out,
  output logic               mem_err
);

  localparam int            CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, state_next;

  logic [4:0]  dest_p0;
  logic [31:0] rt_data_p0;
  logic [31:0] alu_out_p0;
  logic        zero_p0;
  logic [31:0] branch_target_p0;
  logic [5:0]  ctrl_p0;
  logic        mem_op_p0;

  logic [4:0]       dest_p1;
  logic [1:0]       wb_ctrl_p1;
  logic [CNT_W-1:0] cnt_p1;

  logic finish;
  logic timed_out;
  logic unused_ctrl;

  // EX/MEM unpack
  assign dest_p0          = ex_mem_in[107:103];
  assign rt_data_p0       = ex_mem_in[102:71];
  assign alu_out_p0       = ex_mem_in[70:39];
  assign zero_p0          = ex_mem_in[38];
  assign branch_target_p0 = ex_mem_in[37:6];
  assign ctrl_p0          = ex_mem_in[5:0];
  assign mem_op_p0        = ctrl_p0[2] | ctrl_p0[3];
  assign unused_ctrl      = ctrl_p0[5];

  assign pc_src            = ctrl_p0[4] & zero_p0;
  assign branch_target_out = branch_target_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    finish     = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        stall = mem_op_p0;
        if (mem_op_p0) state_next = ACCESS;
      end
      ACCESS: begin
        // A late ack in the final allowed cycle still counts as a real completion.
        if (mem_bus.dmem_ack) begin
          finish = 1'b1;
        end else if (cnt_p1 == CNT_LAST) begin
          finish    = 1'b1;
          timed_out = 1'b1;
        end
        stall = ~finish;
        if (finish) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Upstream must never see a hold while the stage is in reset.
    if (!rst_n) stall = 1'b0;
  end

  // MEM/WB boundary and access holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_bus.dmem_req   <= 1'b0;
      mem_bus.dmem_we    <= 1'b0;
      mem_bus.dmem_addr  <= '0;
      mem_bus.dmem_wdata <= '0;
      dest_p1            <= '0;
      wb_ctrl_p1         <= '0;
      cnt_p1             <= '0;
      mem_wb_out         <= '0;
      mem_err            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op_p0) begin
            dest_p1            <= dest_p0;
            wb_ctrl_p1         <= ctrl_p0[1:0];
            mem_bus.dmem_addr  <= alu_out_p0;
            mem_bus.dmem_wdata <= rt_data_p0;
            mem_bus.dmem_we    <= ctrl_p0[3];
            mem_bus.dmem_req   <= 1'b1;
            cnt_p1             <= '0;
            mem_wb_out         <= '0;
          end else begin
            mem_wb_out <= {dest_p0, 32'h0, alu_out_p0, ctrl_p0[1], ctrl_p0[0]};
          end
        end
        ACCESS: begin
          if (finish) begin
            mem_wb_out <= {dest_p1,
                           (mem_bus.dmem_we | timed_out) ? 32'h0 : mem_bus.dmem_rdata,
                           mem_bus.dmem_addr, wb_ctrl_p1};
            mem_bus.dmem_req <= 1'b0;
            if (timed_out) mem_err <= 1'b1;
          end else begin
            cnt_p1     <= cnt_p1 + 1'b1;
            mem_wb_out <= '0;
          end
        end
        default: mem_bus.dmem_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized instruction
// streams checked against a transaction-level model of the stage.
`timescale 1ns/1ps
module tb_mem_stage;

  localparam int T = 4;

  logic         clk;
  logic         rst_n;
  logic [107:0] ex_mem_in;
  logic         stall;
  logic         pc_src;
  logic [31:0]  branch_target_out;
  logic [70:0]  mem_wb_out;
  logic         mem_err;

  int n_cmp;
  int n_bad;
  logic err_exp;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT(T)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_mem_in         (ex_mem_in),
    .mem_bus           (bus.master),
    .stall             (stall),
    .pc_src            (pc_src),
    .branch_target_out (branch_target_out),
    .mem_wb_out        (mem_wb_out),
    .mem_err           (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  // One instruction through the stage. ack_at = ACCESS cycle index (0-based) at which
  // memory acknowledges; ack_at >= T means memory never answers.
  task automatic run_instr(input string tag, input logic [5:0] ctrl, input logic [4:0] dest,
                           input logic [31:0] rt, input logic [31:0] alu, input logic zero,
                           input logic [31:0] tgt, input int ack_at, input logic [31:0] rdata);
    logic        mem_op, is_store, tmo, last, exp_pc;
    logic [31:0] load_exp;
    logic [70:0] wb_exp;
    mem_op   = ctrl[2] | ctrl[3];
    is_store = ctrl[3];
    tmo      = (ack_at >= T);
    exp_pc   = ctrl[4] & zero;
    @(negedge clk);
    ex_mem_in       = {dest, rt, alu, zero, tgt, ctrl};
    bus.dmem_ack    = 1'($urandom_range(0, 1));
    bus.dmem_rdata  = $urandom;
    #1;
    n_cmp++;
    if (stall !== mem_op) begin
      n_bad++; $display("FAIL %s stall_entry: got %0b want %0b", tag, stall, mem_op);
    end
    n_cmp++;
    if (pc_src !== exp_pc) begin
      n_bad++; $display("FAIL %s pc_src: got %0b want %0b", tag, pc_src, exp_pc);
    end
    n_cmp++;
    if (branch_target_out !== tgt) begin
      n_bad++; $display("FAIL %s branch_target: got %h want %h", tag, branch_target_out, tgt);
    end
    if (!mem_op) begin
      @(posedge clk); #1;
      wb_exp = {dest, 32'h0, alu, ctrl[1], ctrl[0]};
      n_cmp++;
      if (mem_wb_out !== wb_exp) begin
        n_bad++; $display("FAIL %s alu_wb: got %h want %h", tag, mem_wb_out, wb_exp);
      end
      n_cmp++;
      if (bus.dmem_req !== 1'b0) begin
        n_bad++; $display("FAIL %s alu_req: got %0b want 0", tag, bus.dmem_req);
      end
    end else begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus.dmem_req !== 1'b1 || bus.dmem_addr !== alu || bus.dmem_we !== is_store ||
          bus.dmem_wdata !== rt) begin
        n_bad++;
        $display("FAIL %s issue: got req=%0b addr=%h we=%0b wdata=%h want req=1 addr=%h we=%0b wdata=%h",
                 tag, bus.dmem_req, bus.dmem_addr, bus.dmem_we, bus.dmem_wdata, alu, is_store, rt);
      end
      n_cmp++;
      if (mem_wb_out !== 71'h0) begin
        n_bad++; $display("FAIL %s bubble_entry: got %h want 0", tag, mem_wb_out);
      end
      for (int k = 0; k < T; k++) begin
        @(negedge clk);
        bus.dmem_ack   = (k == ack_at);
        bus.dmem_rdata = (k == ack_at) ? rdata : $urandom;
        last           = (k == ack_at) || (k == T - 1);
        #1;
        n_cmp++;
        if (stall !== !last) begin
          n_bad++; $display("FAIL %s stall_wait%0d: got %0b want %0b", tag, k, stall, !last);
        end
        @(posedge clk); #1;
        if (last) begin
          load_exp = (is_store || tmo) ? 32'h0 : rdata;
          wb_exp   = {dest, load_exp, alu, ctrl[1], ctrl[0]};
          n_cmp++;
          if (mem_wb_out !== wb_exp) begin
            n_bad++; $display("FAIL %s mem_wb: got %h want %h", tag, mem_wb_out, wb_exp);
          end
          n_cmp++;
          if (bus.dmem_req !== 1'b0) begin
            n_bad++; $display("FAIL %s req_drop: got %0b want 0", tag, bus.dmem_req);
          end
          break;
        end else begin
          n_cmp++;
          if (mem_wb_out !== 71'h0 || bus.dmem_req !== 1'b1 || bus.dmem_addr !== alu) begin
            n_bad++;
            $display("FAIL %s wait%0d: got wb=%h req=%0b addr=%h want wb=0 req=1 addr=%h",
                     tag, k, mem_wb_out, bus.dmem_req, bus.dmem_addr, alu);
          end
        end
      end
      bus.dmem_ack = 1'b0;
    end
    err_exp = err_exp | (mem_op & tmo);
    n_cmp++;
    if (mem_err !== err_exp) begin
      n_bad++; $display("FAIL %s mem_err: got %0b want %0b", tag, mem_err, err_exp);
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    ex_mem_in      = {5'd3, 32'h1111_2222, 32'h40, 1'b1, 32'h200, 6'b010111};
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    err_exp        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got stall=%0b req=%0b we=%0b want 0 0 0",
                        stall, bus.dmem_req, bus.dmem_we);
    end
    n_cmp++;
    if (bus.dmem_addr !== 32'h0 || bus.dmem_wdata !== 32'h0 || mem_wb_out !== 71'h0 ||
        mem_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_data: got addr=%h wdata=%h wb=%h err=%0b want all 0",
                        bus.dmem_addr, bus.dmem_wdata, mem_wb_out, mem_err);
    end
    n_cmp++;
    if (pc_src !== 1'b1 || branch_target_out !== 32'h200) begin
      n_bad++; $display("FAIL reset_branch: got pc_src=%0b tgt=%h want 1 00000200",
                        pc_src, branch_target_out);
    end
    ex_mem_in = '0;
    rst_n     = 1'b1;
  endtask

  task automatic test_alu();
    run_instr("alu", 6'b000001, 5'd5, 32'h0, 32'h1234, 1'b0, 32'h0, 0, 32'h0);
    run_instr("alu2", 6'b000011, 5'd17, 32'h55, 32'hFFFF_0001, 1'b1, 32'h8, 0, 32'h0);
  endtask

  task automatic test_load();
    run_instr("load", 6'b000111, 5'd9, 32'h0, 32'h40, 1'b0, 32'h0, 2, 32'hDEAD_BEEF);
  endtask

  task automatic test_store();
    run_instr("store", 6'b001000, 5'd2, 32'hCAFE_F00D, 32'h80, 1'b0, 32'h0, 0, 32'h1234_5678);
    run_instr("store_rdwr", 6'b001101, 5'd4, 32'h0BAD_F00D, 32'h84, 1'b0, 32'h0, 1, 32'h9999_9999);
  endtask

  task automatic test_timeout();
    run_instr("timeout", 6'b000111, 5'd12, 32'h0, 32'h100, 1'b0, 32'h0, T, 32'h7777_7777);
    run_instr("after_timeout", 6'b000001, 5'd6, 32'h0, 32'hABCD, 1'b0, 32'h0, 0, 32'h0);
    run_instr("late_ack", 6'b000110, 5'd7, 32'h0, 32'h104, 1'b0, 32'h0, T - 1, 32'h0F0F_0F0F);
  endtask

  task automatic test_branch();
    run_instr("br_taken", 6'b010000, 5'd0, 32'h0, 32'h0, 1'b1, 32'h100, 0, 32'h0);
    run_instr("br_not", 6'b010000, 5'd0, 32'h0, 32'h0, 1'b0, 32'h100, 0, 32'h0);
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    ex_mem_in    = {5'd8, 32'h0, 32'h300, 1'b0, 32'h0, 6'b000111};
    bus.dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.dmem_req !== 1'b0 || stall !== 1'b0) begin
      n_bad++; $display("FAIL midreset_ctrl: got req=%0b stall=%0b want 0 0", bus.dmem_req, stall);
    end
    n_cmp++;
    if (mem_err !== 1'b0 || mem_wb_out !== 71'h0 || bus.dmem_addr !== 32'h0) begin
      n_bad++; $display("FAIL midreset_data: got err=%0b wb=%h addr=%h want 0 0 0",
                        mem_err, mem_wb_out, bus.dmem_addr);
    end
    err_exp = 1'b0;
    @(negedge clk);
    ex_mem_in = '0;
    rst_n     = 1'b1;
    run_instr("load_after_reset", 6'b000111, 5'd8, 32'h0, 32'h300, 1'b0, 32'h0, 1, 32'h1357_9BDF);
  endtask

  task automatic test_random();
    logic [5:0] c;
    for (int i = 0; i < 60; i++) begin
      c = 6'($urandom);
      if (c[4]) c[3:2] = 2'b00;
      run_instr($sformatf("rand%0d", i), c, 5'($urandom), $urandom, $urandom,
                1'($urandom), $urandom, $urandom_range(0, T), $urandom);
    end
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_load", 6'b000111, 5'd1, 32'h0, 32'h10, 1'b0, 32'h0, 0, 32'hA5A5_A5A5);
    run_instr("b2b_store", 6'b001000, 5'd2, 32'h5A5A_5A5A, 32'h14, 1'b0, 32'h0, 0, 32'h0);
    run_instr("b2b_load2", 6'b000110, 5'd3, 32'h0, 32'h18, 1'b0, 32'h0, 0, 32'h0102_0304);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage that consumes the packed EX/MEM bundle, unpacks its fields, and performs loads and stores through a request/acknowledge data-memory port. While an access is pending it stalls the upstream pipeline. It then produces the packed MEM/WB bundle and the branch-resolution outputs. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register.

## Interface
- TIMEOUT, 16: maximum ACCESS cycles to wait for dmem_ack before the access is aborted. Must be ≥1.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_mem_in  in  108  EX/MEM bundle, packed {dest[4:0], rt_data[31:0], alu_out[31:0], zero, branch_target[31:0], ctrl[5:0]}. dest occupies [107:103], ctrl occupies [5:0].
- dmem_rdata  in  32  read data from data memory; sampled when dmem_ack=1.
- dmem_ack  in  1  data memory completion. Ignored outside ACCESS.
- dmem_req  out  1  access request, registered.
- dmem_we  out  1  1=store, 0=load; valid while dmem_req=1.
- dmem_addr  out  32  byte address; stable while dmem_req=1.
- dmem_wdata  out  32  store data; stable while dmem_req=1.
- stall  out  1  upstream hold; the EX/MEM register and earlier stages must not advance while it is 1.
- pc_src  out  1  branch taken: ctrl[4] & zero. Combinational.
- branch_target_out  out  32  branch_target pass-through. Combinational.
- mem_wb_out  out  71  registered {dest[4:0], load_data[31:0], alu_out[31:0], ctrl[1], ctrl[0]}.
- mem_err  out  1  sticky timeout flag.

## Operation
- ctrl fields:
  - ctrl[0] RegWrite
  - ctrl[1] MemtoReg
  - ctrl[2] MemRead
  - ctrl[3] MemWrite
  - ctrl[4] Branch
  - ctrl[5] reserved; ignored.
- mem_op = ctrl[2] | ctrl[3]. If both bits are set, the access is a store (MemWrite wins).
- FSM states: IDLE and ACCESS.
- IDLE, mem_op=0:
  - stall=0.
  - Next edge: mem_wb_out <= {dest, 32'h0, alu_out, ctrl[1], ctrl[0]}.
- IDLE, mem_op=1:
  - stall=1 combinationally in this cycle.
  - Next edge: latch dest, alu_out→dmem_addr, rt_data→dmem_wdata, ctrl[3]→dmem_we, ctrl[1:0] into holding registers.
  - Same edge: dmem_req<=1, timeout counter<=0, mem_wb_out<=0 (bubble), go to ACCESS.
- ACCESS, dmem_ack=0:
  - stall=1; dmem_req and the address/data/we registers hold.
  - counter increments; mem_wb_out stays 0.
- ACCESS, dmem_ack=1:
  - stall=0 in this cycle, so upstream advances at this edge.
  - Next edge: mem_wb_out <= {held dest, dmem_we ? 32'h0 : dmem_rdata, held addr, held ctrl[1:0]}; dmem_req<=0; go to IDLE.
- ACCESS, no ack, counter = TIMEOUT-1:
  - Treated as an ack with rdata=0: stall=0, result written, go to IDLE.
  - mem_err<=1. mem_err is cleared only by reset.
- Upstream contract: ex_mem_in is ignored while in ACCESS. While stall=1, ex_mem_in must stay constant.
- Branches never carry mem_op. pc_src is not qualified by stall.
- Counter width: $clog2(TIMEOUT+1); it never wraps.

## Timing
- Reset state: IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, mem_wb_out=0, mem_err=0, counter=0.
- Reset outputs: stall=0. pc_src and branch_target_out follow ex_mem_in.
- Non-memory instruction: 1-cycle latency, full throughput.
- Memory instruction with ack in the first ACCESS cycle: result appears 2 edges after entry; one bubble is inserted.
- Each extra wait cycle adds 1 cycle.
- Timeout: result appears TIMEOUT+1 edges after entry.
- Back-to-back memory ops: the ack cycle returns to IDLE, which sees the next op one cycle later. Minimum 2 cycles per access.
- Reset asserted mid-ACCESS: immediate return to reset state and dmem_req drops asynchronously. The memory must tolerate an abandoned request.
- dmem_ack in IDLE: no effect.

## Test plan
- ALU op (ctrl=6'b000001, dest=5, alu_out=0x1234) in IDLE → stall=0; next edge mem_wb_out = {5, 0, 0x1234, 0, 1}.
- Load (ctrl=6'b000111, alu_out=0x40), ack with rdata=0xDEADBEEF two cycles after req → stall=1 for 3 cycles; bubble during the wait; mem_wb_out = {dest, 0xDEADBEEF, 0x40, 1, 1}; dmem_addr stable at 0x40 throughout.
- Store (ctrl=6'b001000, rt_data=0xCAFEF00D), same-cycle ack → dmem_we=1 and dmem_wdata=0xCAFEF00D while req=1; 2-cycle latency; mem_wb_out load_data=0.
- No ack, TIMEOUT=4 → req held exactly 4 cycles, then mem_err=1 (sticky), load_data=0, and the following ALU op completes normally.
- Branch (ctrl[4]=1, zero=1, target=0x100) → pc_src=1, branch_target_out=0x100 in the same cycle; zero=0 → pc_src=0.
- rst_n pulled low during ACCESS → dmem_req=0 and stall=0 immediately; all outputs hold reset values; a load after release restarts cleanly.
